cory_rr_arb: RTL and testbench

//  M-to-1 round-robin arbiter with a single registered output stage. Shares one

---
 rtl/cory_rr_arb.sv | 108 ++++++++++
 tb/tb_cory_rr_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cory_rr_arb.sv
// cory_rr_arb: M-to-1 round-robin arbiter with one registered output stage.
//
// M valid/ready requesters share a single downstream slot. The winner is
// chosen combinationally from a rotating priority pointer. Its data and index
// move into a one-deep output register with valid/ready handshaking.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (assert async, release sync)
//   i_a_valid  [M]    request valid per requester
//   i_a_data   [M*N]  request data, requester k at [k*N +: N]
//   o_a_ready  [M]    one-hot (or zero) accept, combinational
//   o_z_valid         registered output valid
//   o_z_data   [N]    registered data of the winner
//   o_z_id     [W]    registered index of the winner
//   i_z_ready         downstream accepts the output item
module cory_rr_arb #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [M-1:0]   i_a_valid,
  input  logic [M*N-1:0] i_a_data,
  output logic [M-1:0]   o_a_ready,
  output logic           o_z_valid,
  output logic [N-1:0]   o_z_data,
  output logic [W-1:0]   o_z_id,
  input  logic           i_z_ready
);

  logic [W-1:0]   ptr;
  logic           vld_p1;
  logic [N-1:0]   data_p1;
  logic [W-1:0]   id_p1;

  logic           load;
  logic           any_valid;
  logic [W-1:0]   grant_id;
  logic [W-1:0]   ptr_nxt;
  logic [M-1:0]   vld_sh;
  logic [M*N-1:0] data_sh;
  logic [N-1:0]   grant_data;

  // ---- stage p0: combinational round-robin arbitration ----
  // First pass finds the lowest valid index overall (the wrapped region).
  // Second pass overrides it with the lowest valid index at or above ptr,
  // which is exactly the search order ptr..M-1, 0..ptr-1.
  always_comb begin
    any_valid = 1'b0;
    grant_id  = '0;
    vld_sh    = '0;
    for (int k = M - 1; k >= 0; k--) begin
      vld_sh = i_a_valid >> k;
      if (vld_sh[0]) begin
        any_valid = 1'b1;
        grant_id  = W'(k);
      end
    end
    for (int k = M - 1; k >= 0; k--) begin
      vld_sh = i_a_valid >> k;
      if (vld_sh[0] && (k >= int'(ptr))) begin
        grant_id = W'(k);
      end
    end
  end

  always_comb begin
    data_sh    = i_a_data >> (int'(grant_id) * N);
    grant_data = data_sh[N-1:0];
  end

  // Pointer moves past the winner, wrapping at M-1 (M need not be 2**W).
  always_comb begin
    if (int'(grant_id) == M - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = grant_id + W'(1);
    end
  end

  // Held in reset: no requester may see an accept.
  assign load      = reset_n && (!vld_p1 || i_z_ready);
  assign o_a_ready = (load && any_valid) ? (M'(1) << grant_id) : '0;

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      ptr     <= '0;
    end else if (load) begin
      vld_p1 <= any_valid;
      if (any_valid) begin
        data_p1 <= grant_data;
        id_p1   <= grant_id;
        ptr     <= ptr_nxt;
      end
    end
  end

  assign o_z_valid = vld_p1;
  assign o_z_data  = data_p1;
  assign o_z_id    = id_p1;

endmodule

// File: tb/tb_cory_rr_arb.sv
// Testbench for cory_rr_arb: scoreboard of expected (id, data) items pushed
// when a grant is predicted and compared when the item sits on the output.
module tb_cory_rr_arb;
  localparam int N = 8;
  localparam int M = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [M-1:0]   i_a_valid;
  logic [M*N-1:0] i_a_data;
  logic [M-1:0]   o_a_ready;
  logic           o_z_valid;
  logic [N-1:0]   o_z_data;
  logic [W-1:0]   o_z_id;
  logic           i_z_ready;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr = 0;
  bit m_vld = 1'b0;
  int q_id[$];
  int q_data[$];

  cory_rr_arb #(.N(N), .M(M), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_a_valid (i_a_valid),
    .i_a_data  (i_a_data),
    .o_a_ready (o_a_ready),
    .o_z_valid (o_z_valid),
    .o_z_data  (o_z_data),
    .o_z_id    (o_z_id),
    .i_z_ready (i_z_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_data(input int base);
    for (int k = 0; k < M; k++) i_a_data[k*N +: N] = N'(base + k);
  endtask

  // Called at a negedge: applies inputs, checks outputs against the model,
  // advances one clock and returns at the following negedge.
  task automatic drive(input logic [M-1:0] v, input logic zr);
    bit load;
    bit any;
    int g;
    int d;
    logic [31:0] exp_rdy;
    i_a_valid = v;
    i_z_ready = zr;
    #1;
    load = !m_vld || zr;
    any  = 1'b0;
    g    = 0;
    for (int i = 0; i < M; i++) begin
      int idx;
      idx = (m_ptr + i) % M;
      if (!any && v[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    exp_rdy = (load && any) ? (32'd1 << g) : 32'd0;
    chk("a_ready", 32'(o_a_ready), exp_rdy);
    chk("z_valid", 32'(o_z_valid), 32'(m_vld));
    if (m_vld) begin
      if (q_id.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_empty: got valid output, expected none queued");
      end else begin
        chk("z_id", 32'(o_z_id), q_id[0]);
        chk("z_data", 32'(o_z_data), q_data[0]);
        if (zr) begin
          void'(q_id.pop_front());
          void'(q_data.pop_front());
        end
      end
    end
    if (load && any) begin
      d = int'(i_a_data[g*N +: N]);
      q_id.push_back(g);
      q_data.push_back(d);
      m_ptr = (g + 1) % M;
    end
    @(posedge clk);
    if (load) m_vld = any;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset with all requesters valid
    reset_n   = 1'b0;
    i_a_valid = 4'b1111;
    i_z_ready = 1'b1;
    set_data(8'hA0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_z_valid", 32'(o_z_valid), 32'd0);
    chk("rst_a_ready", 32'(o_a_ready), 32'd0);
    chk("rst_z_id", 32'(o_z_id), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("first_grant", 32'(o_a_ready), 32'b0001);

    // 2: all valid back-to-back, ids 0,1,2,3,0,... data A0..A3
    repeat (8) drive(4'b1111, 1'b1);
    repeat (3) drive(4'b1111, 1'b1);

    // 3: backpressure with id 2 item held
    chk("bp_hold_id", 32'(o_z_id), 32'd2);
    chk("bp_hold_data", 32'(o_z_data), 32'hA2);
    repeat (5) drive(4'b1111, 1'b0);
    chk("bp_after_id", 32'(o_z_id), 32'd2);
    chk("bp_after_data", 32'(o_z_data), 32'hA2);
    i_z_ready = 1'b1;
    #1;
    chk("bp_release", 32'(o_a_ready), 32'b1000);
    drive(4'b1111, 1'b1);

    // 4: sparse requests on 1 and 3, starting from ptr=2
    set_data(8'h30);
    drive(4'b0010, 1'b1);
    i_a_valid = 4'b1010;
    #1;
    chk("sparse_first", 32'(o_a_ready), 32'b1000);
    repeat (4) drive(4'b1010, 1'b1);

    // 5: idle gap, pointer kept, then single request on id 0
    repeat (2) drive(4'b0000, 1'b1);
    chk("idle_z_valid", 32'(o_z_valid), 32'd0);
    set_data(8'h5C);
    i_a_valid = 4'b0001;
    #1;
    chk("idle_next", 32'(o_a_ready), 32'b0001);
    drive(4'b0001, 1'b1);

    // 6: async reset while the output is valid and stalled
    set_data(8'h71);
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b0);
    chk("pre_rst_valid", 32'(o_z_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_z_valid), 32'd0);
    chk("async_rst_ready", 32'(o_a_ready), 32'd0);
    m_vld = 1'b0;
    m_ptr = 0;
    q_id.delete();
    q_data.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    i_a_valid = 4'b1110;
    i_z_ready = 1'b1;
    #1;
    chk("post_rst_ptr", 32'(o_a_ready), 32'b0010);
    drive(4'b1110, 1'b1);
    drive(4'b1111, 1'b1);
    repeat (2) drive(4'b0000, 1'b1);
    chk("sb_drained", 32'(q_id.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
